bomb_fuse_ctrl: RTL and testbench
=================================

Name: bomb_fuse_ctrl

Overview:
Per-player bomb placement and fuse controller, directly upstream of the bomb/stun FSM. It turns a player's raw bomb button into a placed bomb at the player's current grid cell, runs the fuse timer, then emits a one-cycle detonation pulse with the bomb coordinates. The stun FSM consumes that pulse to decide stuns. One instance is used per player (red, blue).

Parameters:
N, 500, clock cycles per game time unit; must match the stun FSM's N.
FUSE_UNITS, 3, fuse length in time units.
COOLDOWN_UNITS, 2, time units after detonation before the next placement is accepted.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
placeButton  in  1  raw bomb button level, already synchronised to clk
pPosX  in  4  player's current grid X (0..15)
pPosY  in  4  player's current grid Y (0..15)
stunned  in  1  this player's stun enable, from the stun FSM
bombPosX  out  4  latched bomb X; valid while bombArmed or bombButton is high
bombPosY  out  4  latched bomb Y
bombButton  out  1  detonation pulse, exactly one clk cycle wide
bombArmed  out  1  high while a bomb is on the board (fuse running), for the renderer

Behaviour:
- Clocking: single clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values: bombPosX=0, bombPosY=0, bombButton=0, bombArmed=0. State=IDLE, counter=0, button-history register=1.
  - Because history resets to 1, a button held through reset release does not place a bomb. It must be released and pressed again.
- Press detection: press = placeButton & ~prevButton. prevButton is updated every cycle, in every state.
- States: IDLE, ARMED, DETONATE, COOLDOWN. Encodings live in the shared package.
- IDLE:
  - On press with stunned=0, latch pPosX/pPosY into bombPosX/bombPosY.
  - Load counter = FUSE_UNITS*N-1 and go to ARMED.
  - bombArmed rises in the same edge, i.e. it is visible the cycle after the press is sampled.
  - A press with stunned=1 is discarded, not queued.
- ARMED:
  - Counter decrements each cycle. When counter==0, go to DETONATE.
  - bombArmed stays high for exactly FUSE_UNITS*N cycles.
  - Presses are ignored. Player movement does not change bombPos.
  - Stun arriving mid-fuse does not defuse the bomb.
- DETONATE:
  - Lasts one cycle with bombButton=1, bombArmed=0, bombPos held.
  - Load counter = COOLDOWN_UNITS*N-1 and go to COOLDOWN.
- COOLDOWN:
  - bombButton=0, bombArmed=0. bombPos holds its last value.
  - Counter decrements; at 0, go to IDLE.
  - Presses are ignored and not queued. A press on the exact cycle of return to IDLE is also ignored, because the state is still COOLDOWN when it is sampled.
- Latency: press sampled at edge t → bombArmed=1 from t+1 → bombButton=1 in cycle t+1+FUSE_UNITS*N → earliest next accepted press at t+2+(FUSE_UNITS+COOLDOWN_UNITS)*N.
- Counter: 28-bit unsigned. (FUSE_UNITS or COOLDOWN_UNITS)*N must be in 1..2^28-1; the elaboration-time check fails otherwise.
  - COOLDOWN_UNITS=0 is legal: DETONATE returns directly to IDLE.
- Coordinates are latched unmodified. Edge clipping (0 or 15) is the stun FSM's concern.
- Reset mid-operation returns to IDLE immediately. No pulse is emitted and the bomb is discarded.
- Reset has priority over every other event in the same cycle.

Decomposition:
- Shared package bomb_pkg holds:
  - state encoding constants (IDLE=0, ARMED=1, DETONATE=2, COOLDOWN=3);
  - COORD_W=4 and CNT_W=28;
  - default N, shared with the stun FSM.
- One natural sub-module: edge_detect (registered rising-edge detector with configurable reset value), reusable for other player buttons.
- The FSM and counter stay in bomb_fuse_ctrl.

Test Plan:
1. Basic fuse: N=4, FUSE_UNITS=3, COOLDOWN_UNITS=2, pos (5,7), press at cycle 10 → bombArmed high cycles 11–22, bombButton high only in cycle 23, bombPos=(5,7).
2. Movement and re-press: as test 1, but move to (6,7) at cycle 12 and press again at cycles 15 and 25 → bombPos stays (5,7), exactly one pulse at 23, no second bomb. A press at cycle 32 arms again.
3. Stun gating: stunned=1 with press at cycle 10 → nothing armed. stunned drops at cycle 12 with the button still held → still nothing until release and re-press.
4. Reset during fuse: reset at cycle 16 → all outputs 0 from cycle 17, no pulse ever. A fresh press afterwards follows the test 1 timing.
5. Held through reset: placeButton=1 while reset deasserts → no arm. Release then press → arms one cycle later.
6. Edge position (15,0) with COOLDOWN_UNITS=0 → pulse carries (15,0); next press accepted in the cycle after the pulse.

Source files
------------

// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb placement / fuse path and the stun FSM.
//   - fuse_state_t : controller state encoding (IDLE, ARMED, DETONATE, COOLDOWN)
//   - COORD_W      : grid coordinate width (16x16 board)
//   - CNT_W        : width of the fuse / cooldown cycle counter
//   - DEFAULT_N    : clock cycles per game time unit, shared with the stun FSM
package bomb_pkg;

    localparam int COORD_W   = 4;
    localparam int CNT_W     = 28;
    localparam int DEFAULT_N = 500;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        DETONATE = 2'd2,
        COOLDOWN = 2'd3
    } fuse_state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector with a registered history bit.
//   clk   : system clock
//   srst  : synchronous active-high reset, loads the history with RESET_VAL
//   level : input level, already synchronised to clk
//   rise  : high in any cycle where level is 1 and was 0 on the previous edge
// Resetting the history to 1 suppresses a "press" for a level that is
// already high when reset is released.
module edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic srst,
    input  logic level,
    output logic rise
);

    logic prev_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            prev_reg <= RESET_VAL;
        end else begin
            prev_reg <= level;
        end
    end

    assign rise = level & ~prev_reg;

endmodule

// File: rtl/bomb_fuse_ctrl.sv
// Per-player bomb placement and fuse controller.
// A rising edge of placeButton (while not stunned and idle) latches the
// player's grid position, runs a FUSE_UNITS*N cycle fuse, emits a one-cycle
// detonation pulse carrying the bomb coordinates, then blocks new placements
// for COOLDOWN_UNITS*N cycles.
//   clk         : system clock
//   reset       : synchronous active-high reset
//   placeButton : raw bomb button level (synchronised)
//   pPosX/pPosY : player's current grid cell
//   stunned     : player is stunned; presses in IDLE are discarded
//   bombPosX/Y  : latched bomb cell
//   bombButton  : one-cycle detonation pulse
//   bombArmed   : high while the fuse is running
import bomb_pkg::*;

module bomb_fuse_ctrl #(
    parameter int N              = DEFAULT_N,
    parameter int FUSE_UNITS     = 3,
    parameter int COOLDOWN_UNITS = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               placeButton,
    input  logic [COORD_W-1:0] pPosX,
    input  logic [COORD_W-1:0] pPosY,
    input  logic               stunned,
    output logic [COORD_W-1:0] bombPosX,
    output logic [COORD_W-1:0] bombPosY,
    output logic               bombButton,
    output logic               bombArmed
);

    localparam longint FUSE_CYC = longint'(FUSE_UNITS) * longint'(N);
    localparam longint COOL_CYC = longint'(COOLDOWN_UNITS) * longint'(N);
    localparam longint CNT_MAX  = (longint'(1) << CNT_W) - 1;

    generate
        if (FUSE_CYC < 1 || FUSE_CYC > CNT_MAX) begin : g_bad_fuse
            $error("bomb_fuse_ctrl: FUSE_UNITS*N out of counter range");
        end
        if (COOL_CYC < 0 || COOL_CYC > CNT_MAX) begin : g_bad_cool
            $error("bomb_fuse_ctrl: COOLDOWN_UNITS*N out of counter range");
        end
    endgenerate

    // Counters count down to zero inclusive, so they load length-1.
    localparam logic [CNT_W-1:0] FUSE_LOAD = CNT_W'(FUSE_CYC - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD = (COOL_CYC == 0) ? '0 : CNT_W'(COOL_CYC - 1);

    fuse_state_t        state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [COORD_W-1:0] pos_x_reg, pos_x_next;
    logic [COORD_W-1:0] pos_y_reg, pos_y_next;
    logic               armed_reg, armed_next;
    logic               pulse_reg, pulse_next;
    logic               press;

    edge_detect #(
        .RESET_VAL (1'b1)
    ) u_place_edge (
        .clk   (clk),
        .srst  (reset),
        .level (placeButton),
        .rise  (press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            pos_x_reg <= '0;
            pos_y_reg <= '0;
            armed_reg <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pos_x_reg <= pos_x_next;
            pos_y_reg <= pos_y_next;
            armed_reg <= armed_next;
            pulse_reg <= pulse_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pos_x_next = pos_x_reg;
        pos_y_next = pos_y_reg;

        case (state_reg)
            IDLE: begin
                if (press && !stunned) begin
                    pos_x_next = pPosX;
                    pos_y_next = pPosY;
                    cnt_next   = FUSE_LOAD;
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (cnt_reg == '0) begin
                    state_next = DETONATE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            DETONATE: begin
                if (COOL_CYC == 0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next   = COOL_LOAD;
                    state_next = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // Outputs are registered images of the state being entered.
        armed_next = (state_next == ARMED);
        pulse_next = (state_next == DETONATE);
    end

    assign bombPosX   = pos_x_reg;
    assign bombPosY   = pos_y_reg;
    assign bombButton = pulse_reg;
    assign bombArmed  = armed_reg;

endmodule

// File: tb/tb_bomb_fuse_ctrl.sv
// Bench for bomb_fuse_ctrl: two instances sharing inputs (N=4, FUSE_UNITS=3,
// COOLDOWN_UNITS=2 and 0), directed scenarios plus a randomized run checked
// against a timestamp-based reference model.
module tb_bomb_fuse_ctrl;

    localparam int NN = 4;
    localparam int FU = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       placeButton = 1'b0;
    logic       stunned = 1'b0;
    logic [3:0] pPosX = 4'd0;
    logic [3:0] pPosY = 4'd0;

    logic [3:0] bx    [2];
    logic [3:0] by    [2];
    logic       pulse [2];
    logic       armed [2];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: each accepted placement is remembered by the edge
    // index at which it was sampled; everything else follows from timing.
    int         e = 0;
    bit         m_prev = 1'b1;
    bit         m_have [2] = '{1'b0, 1'b0};
    int         m_t    [2] = '{0, 0};
    int         m_ok   [2] = '{0, 0};
    logic [3:0] m_x    [2] = '{4'd0, 4'd0};
    logic [3:0] m_y    [2] = '{4'd0, 4'd0};
    int         cd_units [2] = '{2, 0};

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            bomb_fuse_ctrl #(
                .N              (NN),
                .FUSE_UNITS     (FU),
                .COOLDOWN_UNITS ((gi == 0) ? 2 : 0)
            ) dut (
                .clk         (clk),
                .reset       (reset),
                .placeButton (placeButton),
                .pPosX       (pPosX),
                .pPosY       (pPosY),
                .stunned     (stunned),
                .bombPosX    (bx[gi]),
                .bombPosY    (by[gi]),
                .bombButton  (pulse[gi]),
                .bombArmed   (armed[gi])
            );
        end
    endgenerate

    // Advance one clock edge, update the model with the inputs sampled at
    // that edge, and return at the following negedge.
    task automatic tick();
        @(posedge clk);
        e++;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_have[d] = 1'b0;
                m_ok[d]   = e + 1;
                m_x[d]    = 4'd0;
                m_y[d]    = 4'd0;
            end else if (placeButton && !m_prev && !stunned && e >= m_ok[d]) begin
                m_have[d] = 1'b1;
                m_t[d]    = e;
                m_x[d]    = pPosX;
                m_y[d]    = pPosY;
                m_ok[d]   = e + 2 + (FU + cd_units[d]) * NN;
            end
        end
        m_prev = reset ? 1'b1 : placeButton;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; placeButton = 1'b0; stunned = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; placeButton = 1'b0; stunned = 1'b0;
        pPosX = 4'd9; pPosY = 4'd9;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({armed[d], pulse[d], bx[d], by[d]} !== 10'h000)
                $display("FAIL reset_state dut%0d: got %h expected %h", d,
                         {armed[d], pulse[d], bx[d], by[d]}, 10'h000);
            else n_pass++;
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        pPosX = 4'd5; pPosY = 4'd7; placeButton = 1'b1;
        tick();
        placeButton = 1'b0;
        for (int i = 0; i < FU * NN; i++) begin
            n_checks++;
            if (armed[0] !== 1'b1 || pulse[0] !== 1'b0)
                $display("FAIL basic_armed c%0d: armed=%b pulse=%b expected armed=1 pulse=0",
                         i + 1, armed[0], pulse[0]);
            else n_pass++;
            tick();
        end
        n_checks++;
        if ({armed[0], pulse[0], bx[0], by[0]} !== {1'b0, 1'b1, 4'd5, 4'd7})
            $display("FAIL basic_pulse: got %h expected %h",
                     {armed[0], pulse[0], bx[0], by[0]}, {1'b0, 1'b1, 4'd5, 4'd7});
        else n_pass++;
        tick();
        n_checks++;
        if (pulse[0] !== 1'b0)
            $display("FAIL basic_pulse_width: pulse=%b expected 0", pulse[0]);
        else n_pass++;
    endtask

    task automatic test_move_repress();
        logic [9:0] exp_v;
        do_reset();
        pPosX = 4'd5; pPosY = 4'd7; placeButton = 1'b1;
        tick();
        for (int r = 1; r <= 22; r++) begin
            placeButton = (r == 5 || r == 15 || r == 22);
            pPosX = (r >= 2) ? 4'd6 : 4'd5;
            tick();
            exp_v = {(r < 12 || r == 22), (r == 12), (r == 22) ? 4'd6 : 4'd5, 4'd7};
            n_checks++;
            if ({armed[0], pulse[0], bx[0], by[0]} !== exp_v)
                $display("FAIL move_repress r%0d: got %h expected %h", r,
                         {armed[0], pulse[0], bx[0], by[0]}, exp_v);
            else n_pass++;
        end
        placeButton = 1'b0;
    endtask

    task automatic test_stun();
        do_reset();
        pPosX = 4'd3; pPosY = 4'd3;
        stunned = 1'b1; placeButton = 1'b1;
        tick(); tick();
        stunned = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({armed[0], armed[1]} !== 2'b00)
                $display("FAIL stun_held c%0d: armed=%b%b expected 00", i, armed[0], armed[1]);
            else n_pass++;
        end
        placeButton = 1'b0;
        tick();
        placeButton = 1'b1;
        tick();
        n_checks++;
        if ({armed[0], armed[1], bx[0], by[1]} !== {2'b11, 4'd3, 4'd3})
            $display("FAIL stun_repress: got %h expected %h",
                     {armed[0], armed[1], bx[0], by[1]}, {2'b11, 4'd3, 4'd3});
        else n_pass++;
        placeButton = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        pPosX = 4'd9; pPosY = 4'd2; placeButton = 1'b1;
        tick();
        placeButton = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({armed[d], pulse[d], bx[d], by[d]} !== 10'h000)
                $display("FAIL reset_mid dut%0d: got %h expected %h", d,
                         {armed[d], pulse[d], bx[d], by[d]}, 10'h000);
            else n_pass++;
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if ({pulse[0], armed[0]} !== 2'b00)
                $display("FAIL reset_mid_quiet c%0d: pulse=%b armed=%b expected 0 0",
                         i, pulse[0], armed[0]);
            else n_pass++;
        end
        pPosX = 4'd4; pPosY = 4'd1; placeButton = 1'b1;
        tick();
        placeButton = 1'b0;
        repeat (FU * NN) tick();
        n_checks++;
        if ({armed[0], pulse[0], bx[0], by[0]} !== {1'b0, 1'b1, 4'd4, 4'd1})
            $display("FAIL reset_mid_fresh: got %h expected %h",
                     {armed[0], pulse[0], bx[0], by[0]}, {1'b0, 1'b1, 4'd4, 4'd1});
        else n_pass++;
    endtask

    task automatic test_held_reset();
        reset = 1'b1; placeButton = 1'b1; stunned = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({armed[0], armed[1]} !== 2'b00)
            $display("FAIL held_reset_noarm: armed=%b%b expected 00", armed[0], armed[1]);
        else n_pass++;
        placeButton = 1'b0;
        tick();
        placeButton = 1'b1;
        tick();
        n_checks++;
        if ({armed[0], armed[1]} !== 2'b11)
            $display("FAIL held_reset_arm: armed=%b%b expected 11", armed[0], armed[1]);
        else n_pass++;
        placeButton = 1'b0;
    endtask

    task automatic test_edge_cooldown0();
        do_reset();
        pPosX = 4'd15; pPosY = 4'd0; placeButton = 1'b1;
        tick();
        placeButton = 1'b0;
        repeat (FU * NN) tick();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({pulse[d], bx[d], by[d]} !== {1'b1, 4'd15, 4'd0})
                $display("FAIL edge_pulse dut%0d: got %h expected %h", d,
                         {pulse[d], bx[d], by[d]}, {1'b1, 4'd15, 4'd0});
            else n_pass++;
        end
        tick();
        pPosX = 4'd1; placeButton = 1'b1;
        tick();
        n_checks++;
        if ({armed[1], armed[0], bx[1]} !== {2'b10, 4'd1})
            $display("FAIL cooldown0_rearm: got %h expected %h",
                     {armed[1], armed[0], bx[1]}, {2'b10, 4'd1});
        else n_pass++;
        placeButton = 1'b0;
    endtask

    task automatic test_random();
        bit         arm_e, pul_e;
        logic [9:0] exp_v;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 5) == 0) placeButton = ~placeButton;
            if ($urandom_range(0, 9) == 0) stunned = ~stunned;
            if ($urandom_range(0, 3) == 0) begin
                pPosX = 4'($urandom_range(0, 15));
                pPosY = 4'($urandom_range(0, 15));
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                arm_e = m_have[d] && e >= m_t[d] && e < m_t[d] + FU * NN;
                pul_e = m_have[d] && e == m_t[d] + FU * NN;
                exp_v = {arm_e, pul_e, m_x[d], m_y[d]};
                n_checks++;
                if ({armed[d], pulse[d], bx[d], by[d]} !== exp_v)
                    $display("FAIL random dut%0d edge%0d: got %h expected %h", d, e,
                             {armed[d], pulse[d], bx[d], by[d]}, exp_v);
                else n_pass++;
            end
        end
        reset = 1'b0; placeButton = 1'b0; stunned = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_move_repress();
        test_stun();
        test_reset_mid();
        test_held_reset();
        test_edge_cooldown0();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
